// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the
// clocks-per-sample-tick calculation.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    function automatic int calc_tick_div(input int clk_freq, input int baud_rate,
                                         input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module rx_byte_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    output logic                          full,
    input  logic                          pop,
    output logic [WIDTH-1:0]              dout,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    // Forced to zero when empty so the head byte reads 0 out of reset.
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling 8N1 UART receiver with start-glitch rejection, framing-error
// detection and a receive FIFO drained through a valid/ready handshake.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx,
    output logic [UART_DATA_BITS-1:0]    m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         frame_err,
    output logic                         overrun,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCW      = $clog2(OVERSAMPLE);
    localparam int IW       = $clog2(UART_DATA_BITS);
    localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

    logic                      rx_meta_q, rx_s_q;
    logic [TW-1:0]             tick_cnt_q;
    logic                      tick;
    rx_state_e                 state_q, state_d;
    logic [SCW-1:0]            sc_q, sc_d;
    logic [IW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      byte_push, frame_err_d, overrun_d;
    logic                      frame_err_q, overrun_q;
    logic                      fifo_full, fifo_empty, fifo_pop;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            tick_cnt_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            sc_q      <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            sc_q      <= sc_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (tick) begin
            unique case (state_q)
                RX_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = RX_START;
                        sc_d    = '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at its midpoint was a glitch.
                    if (sc_q == SC_MID) begin
                        sc_d      = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s_q ? RX_IDLE : RX_DATA;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (sc_q == SC_LAST) begin
                        sc_d      = '0;
                        shift_d   = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == IW'(UART_DATA_BITS - 1)) state_d = RX_STOP;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (sc_q == SC_LAST) begin
                        sc_d    = '0;
                        state_d = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s_q) state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_push   = 1'b0;
        frame_err_d = 1'b0;
        if (tick && state_q == RX_STOP && sc_q == SC_LAST) begin
            byte_push   = rx_s_q;
            frame_err_d = !rx_s_q;
        end
        overrun_d = byte_push && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign fifo_pop  = !fifo_empty && m_ready;
    assign m_valid   = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    rx_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (byte_push),
        .din   (shift_q),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (m_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: directed frames, a tick-schedule receiver model
// with a queue-based FIFO, per-cycle output comparison and literal checks.
module tb_uart_rx_buffered;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int DEPTH    = 16;
    localparam int BIT_CLKS = 160;
    localparam int STOP_REL = 8 + 16 * 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid, frame_err, overrun;
    logic [4:0] fifo_count;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    int n_vec = 0;
    int n_miss = 0;
    int n_fe = 0;
    int n_ov = 0;
    byte unsigned dut_drained[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receiver model: samples are taken at fixed tick offsets from the tick
    // where the synchronized line was first seen low.
    int           m_tcnt = 0;
    bit           m_s1 = 1'b1, m_s2 = 1'b1;
    int           m_tick_no = 0;
    int           m_mode = 0;
    int           m_t0 = 0;
    int           m_rel, m_idx;
    bit [7:0]     m_byte = 8'h00;
    byte unsigned m_q[$];
    bit           m_fe = 1'b0, m_ov = 1'b0, m_stop_next = 1'b0;
    bit           m_tick_now, m_rxs, m_push, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tcnt = 0; m_s1 = 1'b1; m_s2 = 1'b1; m_tick_no = 0; m_mode = 0;
            m_t0 = 0; m_byte = 8'h00; m_q.delete(); m_fe = 1'b0; m_ov = 1'b0;
            m_stop_next = 1'b0;
        end else begin
            m_tick_now = (m_tcnt == 9);
            m_rxs  = m_s2;
            m_push = 1'b0;
            m_fe   = 1'b0;
            m_ov   = 1'b0;
            m_pop  = (m_q.size() > 0) && m_ready;
            m_s2 = m_s1;
            m_s1 = rx;
            m_tcnt = m_tick_now ? 0 : m_tcnt + 1;
            if (m_tick_now) begin
                case (m_mode)
                    0: if (!m_rxs) begin m_mode = 1; m_t0 = m_tick_no; end
                    1: begin
                        m_rel = m_tick_no - m_t0;
                        if (m_rel == 8 && m_rxs) begin
                            m_mode = 0;
                        end else if (m_rel > 8 && (m_rel - 8) % 16 == 0) begin
                            m_idx = (m_rel - 8) / 16;
                            if (m_idx <= 8) begin
                                m_byte[m_idx-1] = m_rxs;
                            end else if (m_rxs) begin
                                m_push = 1'b1;
                                m_mode = 0;
                            end else begin
                                m_fe = 1'b1;
                                m_mode = 2;
                            end
                        end
                    end
                    default: if (m_rxs) m_mode = 0;
                endcase
                m_tick_no++;
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_byte);
                else m_ov = 1'b1;
            end
            m_stop_next = (m_mode == 1) && (m_tcnt == 9) && (m_tick_no - m_t0 == STOP_REL);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_valid", m_valid, m_q.size() > 0);
            check("m_data", m_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
            check("fifo_count", fifo_count, m_q.size());
            check("frame_err", frame_err, m_fe);
            check("overrun", overrun, m_ov);
            if (m_valid && m_ready) dut_drained.push_back(m_data);
            if (frame_err) n_fe++;
            if (overrun) n_ov++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
        rx = 1'b0;
        cycles(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(BIT_CLKS);
        end
        rx = stop_bit;
        cycles(stop_len);
        rx = 1'b1;
        cycles(BIT_CLKS);
    endtask

    byte unsigned exp_drain[$];

    initial begin
        cycles(5);
        rst_n = 1'b1;
        cycles(20);

        // Single byte, consumer always ready
        m_ready = 1'b1;
        send_frame(8'h55, 1'b1, BIT_CLKS);
        check("t1_count", fifo_count, 0);

        // Short low pulse is rejected as a glitch
        rx = 1'b0;
        cycles(30);
        rx = 1'b1;
        cycles(200);
        check("t2_valid", m_valid, 0);
        check("t2_count", fifo_count, 0);
        send_frame(8'h81, 1'b1, BIT_CLKS);

        // Stop bit low plus a long break
        send_frame(8'hA3, 1'b0, 400);
        send_frame(8'h3C, 1'b1, BIT_CLKS);
        check("t3_fe_pulses", n_fe, 1);

        // Fill past capacity with the consumer stalled
        m_ready = 1'b0;
        for (int b = 0; b <= 16; b++) send_frame(8'(b), 1'b1, BIT_CLKS);
        check("t4_count", fifo_count, 16);
        check("t4_ov_pulses", n_ov, 1);

        // Pop exactly in the push cycle of 0x77 while full
        fork
            send_frame(8'h77, 1'b1, BIT_CLKS);
            begin
                int k;
                k = 0;
                while (!m_stop_next && k < 2500) begin
                    cycles(1);
                    k++;
                end
                check("t5_stop_seen", m_stop_next, 1);
                m_ready = 1'b1;
                cycles(1);
                m_ready = 1'b0;
            end
        join
        check("t5_count", fifo_count, 16);
        check("t5_ov_pulses", n_ov, 1);
        m_ready = 1'b1;
        cycles(40);
        check("t5_drained", fifo_count, 0);

        // Reset in the middle of a frame with a byte waiting
        m_ready = 1'b0;
        send_frame(8'h5A, 1'b1, BIT_CLKS);
        check("t6_pre_count", fifo_count, 1);
        rx = 1'b0;
        cycles(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = 8'h99 >> i;
            cycles(BIT_CLKS);
        end
        rx = 1'b1;
        cycles(BIT_CLKS / 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_data", m_data, 0);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_fe", frame_err, 0);
        check("t6_rst_ov", overrun, 0);
        cycles(4);
        rst_n = 1'b1;
        cycles(20);
        m_ready = 1'b1;
        send_frame(8'hC7, 1'b1, BIT_CLKS);
        cycles(20);
        check("t6_fe_pulses", n_fe, 1);

        exp_drain = {8'h55, 8'h81, 8'h3C};
        for (int b = 0; b < 16; b++) exp_drain.push_back(8'(b));
        exp_drain.push_back(8'h77);
        exp_drain.push_back(8'hC7);
        check("drain_len", dut_drained.size(), exp_drain.size());
        for (int i = 0; i < exp_drain.size(); i++) begin
            check($sformatf("drain[%0d]", i),
                  (i < dut_drained.size()) ? dut_drained[i] : 32'hFFFF_FFFF, exp_drain[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
